// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported sram between the
// inst-fetch and load/store requesters with starvation protection.
module sram_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_req,
  input  logic [DATA_W/8-1:0] inst_we,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                stallreq_inst,
  output logic                stallreq_data,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  logic [3:0]        streak;
  owner_t            rd_owner;
  owner_t            owner_next;
  logic [DATA_W-1:0] inst_hold;
  logic [DATA_W-1:0] data_hold;
  logic              both;
  logic              force_inst;

  assign both       = inst_req & data_req;
  assign force_inst = (streak == LIMIT);

  // grant arbitration; nothing is granted while in reset
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        inst_req & ~data_req: inst_gnt = 1'b1;
        data_req & ~inst_req: data_gnt = 1'b1;
        both & force_inst:    inst_gnt = 1'b1;
        both & ~force_inst:   data_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  // steer the granted requester onto the sram port
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (1'b1)
      inst_gnt: begin
        sram_en    = 1'b1;
        sram_we    = inst_we;
        sram_addr  = inst_addr;
        sram_wdata = inst_wdata;
      end
      data_gnt: begin
        sram_en    = 1'b1;
        sram_we    = data_we;
        sram_addr  = data_addr;
        sram_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  // who owns the read data returning next cycle
  always_comb begin
    owner_next = OWN_NONE;
    unique case (1'b1)
      inst_gnt & (inst_we == '0): owner_next = OWN_INST;
      data_gnt & (data_we == '0): owner_next = OWN_DATA;
      default: ;
    endcase
  end

  // read-owner register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_owner <= OWN_NONE;
    else        rd_owner <= owner_next;
  end

  // count data grants that made a waiting inst requester stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!inst_req || inst_gnt) begin
      streak <= '0;
    end else if (data_gnt && streak != LIMIT) begin
      streak <= streak + 4'd1;
    end
  end

  // hold the last returned word for each requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      if (rd_owner == OWN_INST) inst_hold <= sram_rdata;
      if (rd_owner == OWN_DATA) data_hold <= sram_rdata;
    end
  end

  assign inst_rvalid = (rd_owner == OWN_INST);
  assign data_rvalid = (rd_owner == OWN_DATA);
  assign inst_rdata  = inst_rvalid ? sram_rdata : inst_hold;
  assign data_rdata  = data_rvalid ? sram_rdata : data_hold;

  assign stallreq_inst = rst_n & inst_req & ~inst_gnt;
  assign stallreq_data = rst_n & data_req & ~data_gnt;

  logic unused_be;
  assign unused_be = (BE_W == 0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of the shared sram arbiter
// against a byte-enabled one-cycle-latency sram model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        inst_req;
  logic [7:0]  inst_we;
  logic [63:0] inst_addr;
  logic [63:0] inst_wdata;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [63:0] inst_rdata;
  logic        data_req;
  logic [7:0]  data_we;
  logic [63:0] data_addr;
  logic [63:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [63:0] data_rdata;
  logic        stallreq_inst;
  logic        stallreq_data;
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [63:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] M0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] M1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] M2 = 64'h9999_AAAA_BBBB_CCCC;

  logic [63:0] mem [0:255];

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_we(inst_we),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .stallreq_inst(stallreq_inst),
    .stallreq_data(stallreq_data),
    .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram model: one-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 8'h00) begin
        sram_rdata <= mem[sram_addr[10:3]];
      end else begin
        for (int b = 0; b < 8; b++)
          if (sram_we[b])
            mem[sram_addr[10:3]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic idle();
    inst_req = 1'b0; inst_we = 8'h00;
    data_req = 1'b0; data_we = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst_req = 1'b1; inst_we = 8'h00;
    inst_addr = 64'h8000_0000; inst_wdata = 64'h0;
    data_req = 1'b1; data_we = 8'hFF;
    data_addr = 64'h40; data_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #12;
    checks++;
    if ({sram_en, sram_we} !== 9'h0) begin
      errors++;
      $display("FAIL rst_sram_en_we got %h exp 0", {sram_en, sram_we});
    end
    checks++;
    if ({sram_addr, sram_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL rst_sram_addr_wdata got %h exp 0",
               {sram_addr, sram_wdata});
    end
    checks++;
    if ({inst_gnt, data_gnt, stallreq_inst, stallreq_data} !== 4'h0) begin
      errors++;
      $display("FAIL rst_gnt_stall got %b exp 0000",
               {inst_gnt, data_gnt, stallreq_inst, stallreq_data});
    end
    checks++;
    if ({inst_rvalid, data_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_rvalid got %b exp 00", {inst_rvalid, data_rvalid});
    end
    data_req = 1'b0; data_we = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({inst_gnt, sram_en, sram_addr} !== {2'b11, 64'h8000_0000}) begin
      errors++;
      $display("FAIL rel_first_grant got %b%b %h exp 11 80000000",
               inst_gnt, sram_en, sram_addr);
    end
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    checks++;
    if ({inst_rvalid, inst_rdata} !== {1'b1, M0}) begin
      errors++;
      $display("FAIL rel_first_rdata got %b %h exp 1 %h",
               inst_rvalid, inst_rdata, M0);
    end
  endtask

  task automatic test_data_write();
    @(negedge clk);
    data_req = 1'b1; data_we = 8'h0F;
    data_addr = 64'h100; data_wdata = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if ({data_gnt, sram_we, sram_wdata, stallreq_data} !==
        {1'b1, 8'h0F, 64'h1122_3344_5566_7788, 1'b0}) begin
      errors++;
      $display("FAIL wr_grant got %b %h %h %b", data_gnt, sram_we,
               sram_wdata, stallreq_data);
    end
    @(negedge clk);
    data_we = 8'h00;
    #1;
    checks++;
    if ({data_gnt, data_rvalid, inst_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL wr_no_rvalid got %b exp 100",
               {data_gnt, data_rvalid, inst_rvalid});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({data_rvalid, data_rdata} !== {1'b1, 64'h0000_0000_5566_7788}) begin
      errors++;
      $display("FAIL wr_readback got %b %h exp 1 0000000055667788",
               data_rvalid, data_rdata);
    end
  endtask

  task automatic test_contention();
    logic ei;
    @(negedge clk);
    inst_req = 1'b1; inst_we = 8'h00; inst_addr = 64'h10;
    data_req = 1'b1; data_we = 8'h00; data_addr = 64'h8;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      ei = (c == 5);
      checks++;
      if ({inst_gnt, data_gnt, stallreq_inst, stallreq_data} !==
          {ei, ~ei, ~ei, ei}) begin
        errors++;
        $display("FAIL cont_grant c%0d got %b exp %b", c,
                 {inst_gnt, data_gnt, stallreq_inst, stallreq_data},
                 {ei, ~ei, ~ei, ei});
      end
      if (c > 1) begin
        checks++;
        if (c == 6) begin
          if ({inst_rvalid, data_rvalid, inst_rdata} !== {2'b10, M2}) begin
            errors++;
            $display("FAIL cont_rd c%0d got %b%b %h exp 10 %h", c,
                     inst_rvalid, data_rvalid, inst_rdata, M2);
          end
        end else begin
          if ({inst_rvalid, data_rvalid, data_rdata} !== {2'b01, M1}) begin
            errors++;
            $display("FAIL cont_rd c%0d got %b%b %h exp 01 %h", c,
                     inst_rvalid, data_rvalid, data_rdata, M1);
          end
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_streak_restart();
    logic ireq [8] = '{1, 0, 1, 1, 1, 1, 1, 1};
    logic eig  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    @(negedge clk);
    data_req = 1'b1; data_we = 8'h00; data_addr = 64'h8;
    inst_we = 8'h00; inst_addr = 64'h10;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      inst_req = ireq[c];
      #1;
      checks++;
      if ({inst_gnt, data_gnt, stallreq_inst} !==
          {eig[c], ~eig[c], ireq[c] & ~eig[c]}) begin
        errors++;
        $display("FAIL streak c%0d got %b exp %b", c,
                 {inst_gnt, data_gnt, stallreq_inst},
                 {eig[c], ~eig[c], ireq[c] & ~eig[c]});
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    logic ir [5] = '{1, 0, 1, 0, 0};
    logic dr [5] = '{0, 1, 0, 1, 0};
    @(negedge clk);
    idle();
    inst_addr = 64'h0; data_addr = 64'h8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      inst_req = ir[c]; data_req = dr[c];
      #1;
      checks++;
      if ({inst_gnt, data_gnt} !== {ir[c], dr[c]}) begin
        errors++;
        $display("FAIL b2b_gnt c%0d got %b%b exp %b%b", c,
                 inst_gnt, data_gnt, ir[c], dr[c]);
      end
      if (c > 0) begin
        checks++;
        if ({inst_rvalid, data_rvalid, inst_rdata, data_rdata} !==
            {ir[c-1], dr[c-1], M0, M1}) begin
          errors++;
          $display("FAIL b2b_rd c%0d got %b%b %h %h exp %b%b %h %h", c,
                   inst_rvalid, data_rvalid, inst_rdata, data_rdata,
                   ir[c-1], dr[c-1], M0, M1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    inst_req = 1'b1; inst_we = 8'h00; inst_addr = 64'h8;
    #1;
    checks++;
    if (inst_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt got %b exp 1", inst_gnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inst_rvalid, inst_gnt, sram_en, stallreq_inst} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_outs got %b exp 0000",
               {inst_rvalid, inst_gnt, sram_en, stallreq_inst});
    end
    idle();
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({inst_rvalid, data_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL mid_no_rvalid c%0d got %b exp 00", c,
                 {inst_rvalid, data_rvalid});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[0] = M0;
    mem[1] = M1;
    mem[2] = M2;
    sram_rdata = 64'h0;
    test_reset();
    test_data_write();
    test_contention();
    test_streak_restart();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported 64-bit sram instance between the pipeline's instruction-fetch requester and its load/store requester.
- This replaces the separate inst and data sram instances at the top level.
- Grants at most one request per cycle and steers the sram's one-cycle-latency read data back to the owner.
- Raises per-requester stall requests so the pipeline holds while it is not granted.

Parameters:
- ADDR_W, 64, address width of requesters and sram.
- DATA_W, 64, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive data grants allowed while inst is waiting before inst is forced through (1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- inst_req  input  1  inst requester wants an access this cycle
- inst_we  input  8  inst byte write enables (0 = read)
- inst_addr  input  64  inst address
- inst_wdata  input  64  inst write data
- inst_gnt  output  1  inst access accepted this cycle
- inst_rvalid  output  1  inst_rdata valid (cycle after a granted inst read)
- inst_rdata  output  64  inst read data
- data_req  input  1  data requester wants an access
- data_we  input  8  data byte write enables
- data_addr  input  64  data address
- data_wdata  input  64  data write data
- data_gnt  output  1  data access accepted
- data_rvalid  output  1  data read data valid
- data_rdata  output  64  data read data
- stallreq_inst  output  1  inst_req & ~inst_gnt
- stallreq_data  output  1  data_req & ~data_gnt
- sram_en  output  1  to sram en
- sram_we  output  8  to sram we
- sram_addr  output  64  to sram addr
- sram_wdata  output  64  to sram wdata
- sram_rdata  input  64  from sram, valid the cycle after en with we==0

Behaviour:
- Reset (async, rst_n low):
  - streak counter = 0, rd_owner = NONE, both rvalid = 0.
  - All sram outputs are 0 while in reset.
- Grant is combinational in the request cycle.
- Grant decision, in priority order:
  - Only one requester asserts req: that requester is granted.
  - Both assert req and streak == STARVE_LIMIT: inst is granted.
  - Both assert req otherwise: data is granted.
  - Neither asserts req: no grant; sram_en = 0 and sram_we/addr/wdata = 0.
- The granted requester's we/addr/wdata drive the sram outputs unmodified; sram_en = 1.
- Requesters hold req/we/addr/wdata stable until their gnt is seen.
- Streak counter (sequential):
  - Increments on a data grant while inst_req = 1; saturates at STARVE_LIMIT.
  - Clears on an inst grant, or in any cycle with inst_req = 0.
- rd_owner register records which requester issued a read:
  - Set to INST or DATA on a granted access with we == 0; set to NONE otherwise.
  - Next cycle: that owner's rvalid = 1 and its rdata = sram_rdata; the other rvalid = 0.
  - rdata of a non-owner is held at its last value (not required to be 0).
- Writes produce no rvalid; a write completes in its grant cycle.
- Back-to-back grants to either requester are allowed every cycle. Read data of access N returns in the same cycle that access N+1 is granted.
- Reset asserted mid-read: the pending rvalid is dropped and not emitted after reset release.
- Latency: read grant at cycle T -> rvalid at T+1; zero bubbles.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately and stay 0. Release -> first inst_req read at addr 0x8000_0000 is granted the same cycle; inst_rvalid is high the next cycle with the sram word.
- Single data write: data_req, data_we = 8'h0F, addr 0x100, wdata 0x1122334455667788 -> data_gnt = 1, sram_we = 8'h0F, no rvalid. A following read of 0x100 returns 0x0000000055667788 on data_rdata.
- Contention: both req held continuously, data reads -> data granted 4 consecutive cycles with stallreq_inst = 1; the 5th cycle grants inst, the streak clears, and data is granted again on the 6th.
- inst_req drops at cycle 2 of a data streak and returns later -> streak restarts at 0. Inst waits a full 4 data grants before being forced.
- Back-to-back reads alternating inst/data addresses 0x0, 0x8 -> each rvalid goes only to the issuing requester one cycle later, and its rdata matches the sram contents.
- Read granted, then rst_n pulsed low before the next edge -> no rvalid after release; rd_owner = NONE.
